// File: rtl/fg_pkg.sv
// Shared types for the function-generator sequencer: FSM encoding, default widths, config bundle.
// Latency: n/a. Backpressure: n/a.
// Contains no logic; only types and constants.
package fg_pkg;

    localparam int FG_COUNTER_BW   = 32;
    localparam int FG_WAVEFORM_BW  = 16;
    localparam int FG_PRESCALER_BW = 16;
    localparam int FG_BURST_BW     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } fg_state_e;

    typedef struct packed {
        logic [FG_COUNTER_BW-1:0]   period;
        logic [FG_COUNTER_BW-1:0]   on;
        logic [FG_WAVEFORM_BW-1:0]  k_rise;
        logic [FG_WAVEFORM_BW-1:0]  k_fall;
        logic [FG_WAVEFORM_BW-1:0]  amplitude;
        logic [FG_PRESCALER_BW-1:0] prescaler;
        logic [FG_BURST_BW-1:0]     burst;
    } fg_cfg_t;

endpackage

// File: rtl/fg_prescaler.sv
// Sample-rate divider: one-cycle tick every limit+1 clocks while running, synchronous clear.
// Latency: tick is registered; first tick arrives limit+1 clocks after the clear cycle.
// Backpressure: none; counts freely whenever run is requested.
module fg_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tick_d;

    // run_i and limit_i describe the next cycle, so the tick can be registered yet
    // still coincide with the cycle where the count equals the limit.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clr_i || !run_i || tick_o) begin
            cnt_d = '0;
        end
        tick_d = run_i && (cnt_d == limit_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_o <= tick_d;
        end
    end

endmodule

// File: rtl/fg_sequencer.sv
// Function-generator timebase: sample strobe, period counter, burst control, double-buffered config.
// Latency: new config visible the cycle after a wrap strobe (or one cycle after handshake in IDLE).
// Backpressure: cfg_ready_o low while a pending config waits for its period boundary.
module fg_sequencer
    import fg_pkg::*;
#(
    parameter int COUNTER_BITWIDTH   = FG_COUNTER_BW,
    parameter int WAVEFORM_BITWIDTH  = FG_WAVEFORM_BW,
    parameter int PRESCALER_BITWIDTH = FG_PRESCALER_BW,
    parameter int BURST_BITWIDTH     = FG_BURST_BW
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          enable_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [COUNTER_BITWIDTH-1:0]   cfg_period_i,
    input  logic [COUNTER_BITWIDTH-1:0]   cfg_on_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_rise_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_fall_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_amplitude_i,
    input  logic [PRESCALER_BITWIDTH-1:0] cfg_prescaler_i,
    input  logic [BURST_BITWIDTH-1:0]     cfg_burst_i,
    output logic                          strb_data_valid_o,
    output logic [COUNTER_BITWIDTH-1:0]   counterValue_o,
    output logic [COUNTER_BITWIDTH-1:0]   counter_o,
    output logic [COUNTER_BITWIDTH-1:0]   ON_counter_o,
    output logic [WAVEFORM_BITWIDTH-1:0]  k_rise_o,
    output logic [WAVEFORM_BITWIDTH-1:0]  k_fall_o,
    output logic [WAVEFORM_BITWIDTH-1:0]  amplitude_o,
    output logic                          busy_o,
    output logic                          period_done_o,
    output logic                          burst_done_o
);

    fg_state_e               state_q, state_d;
    fg_cfg_t                 pend_q, act_q, act_d, cfg_in;
    logic                    pend_full_q;
    logic [FG_COUNTER_BW-1:0] cv_q;
    logic [FG_BURST_BW-1:0]  burst_q;
    logic                    busy_q, period_done_q, burst_done_q;
    logic                    strb, wrap, hs, start, copy, last;

    assign hs   = cfg_valid_i && !pend_full_q;
    assign wrap = strb && (cv_q == act_q.period);

    always_comb begin
        cfg_in           = '0;
        cfg_in.period    = FG_COUNTER_BW'(cfg_period_i);
        cfg_in.on        = FG_COUNTER_BW'(cfg_on_i);
        cfg_in.k_rise    = FG_WAVEFORM_BW'(cfg_k_rise_i);
        cfg_in.k_fall    = FG_WAVEFORM_BW'(cfg_k_fall_i);
        cfg_in.amplitude = FG_WAVEFORM_BW'(cfg_amplitude_i);
        cfg_in.prescaler = FG_PRESCALER_BW'(cfg_prescaler_i);
        cfg_in.burst     = FG_BURST_BW'(cfg_burst_i);
    end

    // A config accepted on a wrap cycle has pend_full_q low there, so it naturally
    // waits for the following wrap before being copied.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        copy    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    copy = 1'b1;
                end else if (enable_i) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                copy = wrap && pend_full_q;
                if (wrap && (act_q.burst != '0) && (burst_q == FG_BURST_BW'(1))) begin
                    state_d = ST_IDLE;
                    last    = 1'b1;
                end else if (!enable_i) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (enable_i) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        act_d = copy ? pend_q : act_q;
    end

    fg_prescaler #(
        .WIDTH (FG_PRESCALER_BW)
    ) u_prescaler (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .run_i   (state_d != ST_IDLE),
        .clr_i   (start),
        .limit_i (act_d.prescaler),
        .tick_o  (strb)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            act_q         <= '0;
            cv_q          <= '0;
            burst_q       <= '0;
            busy_q        <= 1'b0;
            period_done_q <= 1'b0;
            burst_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            if (hs) begin
                pend_q <= cfg_in;
            end
            if (copy) begin
                pend_full_q <= 1'b0;
            end else if (hs) begin
                pend_full_q <= 1'b1;
            end
            if (start) begin
                cv_q <= '0;
            end else if (strb) begin
                cv_q <= wrap ? '0 : cv_q + FG_COUNTER_BW'(1);
            end
            if (start) begin
                burst_q <= act_q.burst;
            end else if ((state_q == ST_RUN) && wrap && (burst_q != '0)) begin
                burst_q <= burst_q - FG_BURST_BW'(1);
            end
            busy_q        <= (state_d != ST_IDLE);
            period_done_q <= wrap;
            burst_done_q  <= last;
        end
    end

    assign cfg_ready_o       = !pend_full_q;
    assign strb_data_valid_o = strb;
    assign counterValue_o    = COUNTER_BITWIDTH'(cv_q);
    assign counter_o         = COUNTER_BITWIDTH'(act_q.period);
    assign ON_counter_o      = COUNTER_BITWIDTH'(act_q.on);
    assign k_rise_o          = WAVEFORM_BITWIDTH'(act_q.k_rise);
    assign k_fall_o          = WAVEFORM_BITWIDTH'(act_q.k_fall);
    assign amplitude_o       = WAVEFORM_BITWIDTH'(act_q.amplitude);
    assign busy_o            = busy_q;
    assign period_done_o     = period_done_q;
    assign burst_done_o      = burst_done_q;

endmodule
